// File: rtl/square_motion_ctrl.sv
// Moves a fixed-size square around the OLED one pixel per step period in the
// direction of the last button press, stopping at the screen edges.
module square_motion_ctrl #(
  parameter int SCREEN_W    = 96,
  parameter int SCREEN_H    = 64,
  parameter int SQ_LEN      = 9,
  parameter int STEP_CYCLES = 1250000,
  parameter int X_INIT      = 43,
  parameter int Y_INIT      = 27
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btnU,
  input  logic        btnD,
  input  logic        btnL,
  input  logic        btnR,
  input  logic        btnC,
  input  logic [12:0] pixel_index,
  output logic [7:0]  X_coord_start,
  output logic [7:0]  Y_coord_start,
  output logic [7:0]  length,
  output logic        moving
);

  localparam int CW = (STEP_CYCLES > 2) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(STEP_CYCLES - 1);
  localparam logic [7:0] X_MAX = 8'(SCREEN_W - 1 - SQ_LEN);
  localparam logic [7:0] Y_MAX = 8'(SCREEN_H - 1 - SQ_LEN);

  typedef enum logic {IDLE, RUN} state_t;
  typedef enum logic [1:0] {UP, DOWN, LEFT, RIGHT} dir_t;

  state_t        state, state_n;
  dir_t          dir, dir_n, dir_press;
  logic [CW-1:0] cnt, cnt_n;
  logic [7:0]    xw, xw_n, yw, yw_n;
  logic [4:0]    btn_q;
  logic          armed;
  logic [4:0]    press;
  logic          press_c, press_dir;

  assign length = 8'(SQ_LEN);

  // Order is {C, U, D, L, R}; armed masks the first cycle after reset so a
  // button held through reset release is absorbed rather than seen as a press.
  assign press     = {btnC, btnU, btnD, btnL, btnR} & ~btn_q & {5{armed}};
  assign press_c   = press[4];
  assign press_dir = |press[3:0];

  always_comb begin
    dir_press = RIGHT;
    if (press[3])      dir_press = UP;
    else if (press[2]) dir_press = DOWN;
    else if (press[1]) dir_press = LEFT;
  end

  always_comb begin
    state_n = state;
    dir_n   = dir;
    cnt_n   = cnt;
    xw_n    = xw;
    yw_n    = yw;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (!press_c && press_dir) begin
          dir_n   = dir_press;
          state_n = RUN;
        end
      end
      RUN: begin
        if (press_c) begin
          cnt_n   = '0;
          state_n = IDLE;
        end else if (press_dir) begin
          dir_n = dir_press;
          cnt_n = '0;
        end else if (cnt == CNT_LAST) begin
          cnt_n = '0;
          // Stop in the same cycle the square reaches, or already sits on, the limit.
          case (dir)
            UP: begin
              if (yw == 8'd0) state_n = IDLE;
              else begin
                yw_n = yw - 8'd1;
                if (yw == 8'd1) state_n = IDLE;
              end
            end
            DOWN: begin
              if (yw >= Y_MAX) state_n = IDLE;
              else begin
                yw_n = yw + 8'd1;
                if (yw == Y_MAX - 8'd1) state_n = IDLE;
              end
            end
            LEFT: begin
              if (xw == 8'd0) state_n = IDLE;
              else begin
                xw_n = xw - 8'd1;
                if (xw == 8'd1) state_n = IDLE;
              end
            end
            default: begin
              if (xw >= X_MAX) state_n = IDLE;
              else begin
                xw_n = xw + 8'd1;
                if (xw == X_MAX - 8'd1) state_n = IDLE;
              end
            end
          endcase
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      dir           <= RIGHT;
      cnt           <= '0;
      btn_q         <= '0;
      armed         <= 1'b0;
      xw            <= 8'(X_INIT);
      yw            <= 8'(Y_INIT);
      X_coord_start <= 8'(X_INIT);
      Y_coord_start <= 8'(Y_INIT);
      moving        <= 1'b0;
    end else begin
      state  <= state_n;
      dir    <= dir_n;
      cnt    <= cnt_n;
      btn_q  <= {btnC, btnU, btnD, btnL, btnR};
      armed  <= 1'b1;
      xw     <= xw_n;
      yw     <= yw_n;
      moving <= (state_n == RUN);
      // Only update the displayed position at frame start to avoid tearing.
      if (pixel_index == 13'd0) begin
        X_coord_start <= xw;
        Y_coord_start <= yw;
      end
    end
  end

endmodule
